// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one XNOR LFSR between several consumers.
// Enforces a minimum step gap between draws and handles reseed and lockup.
module rng_arbiter #(
    parameter int                     NUM_REQ  = 4,
    parameter int                     NUM_BITS = 8,
    parameter int                     MIN_GAP  = 8,
    parameter logic [NUM_BITS-1:0]    SEED     = 8'h5A
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  ack,
    output logic [NUM_BITS-1:0] rnd_data,
    input  logic                reseed,
    input  logic [NUM_BITS-1:0] reseed_value,
    output logic                lfsr_load,
    output logic [NUM_BITS-1:0] lfsr_seed,
    input  logic [NUM_BITS-1:0] lfsr_state,
    output logic                busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GW = $clog2(MIN_GAP + 1);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_WAIT,
        S_RESEED
    } state_t;

    state_t              r_state;
    logic [NUM_REQ-1:0]  r_ack;
    logic [NUM_BITS-1:0] r_rnd;
    logic [NUM_BITS-1:0] r_pend_seed;
    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       r_win;
    logic [GW-1:0]       r_gap;
    logic                r_pending;

    logic                w_load;
    logic                w_gap_full;
    logic                w_lockup;
    logic                w_found;
    logic [PW-1:0]       w_pick;
    logic                w_draw;
    logic [PW-1:0]       w_draw_idx;
    logic [PW-1:0]       w_next_ptr;
    logic [NUM_BITS-1:0] w_seed_in;
    int                  w_idx;

    assign w_load     = (r_state == S_INIT) || (r_state == S_RESEED);
    assign w_gap_full = (r_gap == GW'(MIN_GAP));
    assign w_lockup   = &lfsr_state;
    assign w_seed_in  = (&reseed_value) ? SEED : reseed_value;

    assign lfsr_load  = w_load;
    assign lfsr_seed  = (r_state == S_INIT) ? SEED : r_pend_seed;
    assign busy       = (r_state != S_IDLE);
    assign ack        = r_ack;
    assign rnd_data   = r_rnd;

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = (int'(r_ptr) + i) % NUM_REQ;
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = PW'(w_idx);
            end
        end
    end

    always_comb begin
        w_draw     = 1'b0;
        w_draw_idx = r_win;
        if (r_state == S_IDLE) begin
            w_draw     = !r_pending && !w_lockup && w_found && w_gap_full;
            w_draw_idx = w_pick;
        end else if (r_state == S_WAIT) begin
            w_draw     = req[r_win] && w_gap_full;
            w_draw_idx = r_win;
        end
    end

    assign w_next_ptr = (w_draw_idx == PW'(NUM_REQ - 1)) ? '0
                                                         : w_draw_idx + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_INIT;
            r_ack       <= '0;
            r_rnd       <= '0;
            r_ptr       <= '0;
            r_win       <= '0;
            r_gap       <= '0;
            r_pending   <= 1'b0;
            r_pend_seed <= SEED;
        end else begin
            r_ack <= '0;

            if (w_load || w_draw) begin
                r_gap <= '0;
            end else if (!w_gap_full) begin
                r_gap <= r_gap + GW'(1);
            end

            if (w_draw) begin
                r_ack <= NUM_REQ'(1) << w_draw_idx;
                r_rnd <= lfsr_state;
                r_ptr <= w_next_ptr;
            end

            case (r_state)
                S_INIT: begin
                    r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (r_pending) begin
                        r_state <= S_RESEED;
                    end else if (w_lockup) begin
                        r_pend_seed <= SEED;
                        r_state     <= S_RESEED;
                    end else if (w_found) begin
                        r_win <= w_pick;
                        if (!w_gap_full) begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!req[r_win] || w_gap_full) begin
                        r_state <= S_IDLE;
                    end
                end
                S_RESEED: begin
                    r_pending <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase

            // A fresh strobe wins over the lockup seed and the RESEED clear.
            if (reseed) begin
                r_pending   <= 1'b1;
                r_pend_seed <= w_seed_in;
            end
        end
    end

endmodule

// File: tb/tb_rng_arbiter.sv
// Self-checking bench for rng_arbiter: randomized LFSR values and
// request patterns checked against a round-robin/gap reference model.
module tb_rng_arbiter;

    localparam int MIN_GAP = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] ack;
    logic [7:0] rnd_data;
    logic       reseed;
    logic [7:0] reseed_value;
    logic       lfsr_load;
    logic [7:0] lfsr_seed;
    logic [7:0] lfsr_state;
    logic       busy;

    int         checks;
    int         errors;
    int         m_ptr;
    bit         rand_lfsr;
    logic [7:0] pre;

    rng_arbiter #(
        .NUM_REQ (4),
        .NUM_BITS(8),
        .MIN_GAP (MIN_GAP),
        .SEED    (8'h5A)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .ack         (ack),
        .rnd_data    (rnd_data),
        .reseed      (reseed),
        .reseed_value(reseed_value),
        .lfsr_load   (lfsr_load),
        .lfsr_seed   (lfsr_seed),
        .lfsr_state  (lfsr_state),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rnd8();
        return 8'($urandom_range(0, 254));
    endfunction

    function automatic logic [3:0] pick(input logic [3:0] r, input int p);
        int idx;
        for (int i = 0; i < 4; i++) begin
            idx = (p + i) % 4;
            if (r[idx]) return 4'(1 << idx);
        end
        return 4'b0000;
    endfunction

    function automatic int after(input logic [3:0] w);
        for (int i = 0; i < 4; i++)
            if (w[i]) return (i + 1) % 4;
        return 0;
    endfunction

    task automatic tick();
        pre = lfsr_state;
        @(posedge clk);
        #1;
        if (rand_lfsr) lfsr_state = rnd8();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_ack(input int lim, output logic [3:0] a,
                            output int n, output logic [7:0] s);
        a = 4'b0000;
        n = 0;
        s = 8'h00;
        while (n < lim && a == 4'b0000) begin
            tick();
            n++;
            a = ack;
            s = pre;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks += 5;
        if (lfsr_load !== 1'b1) begin
            errors++; $display("FAIL rst_load: got %b want 1", lfsr_load);
        end
        if (lfsr_seed !== 8'h5A) begin
            errors++; $display("FAIL rst_seed: got %h want 5a", lfsr_seed);
        end
        if (ack !== 4'b0000) begin
            errors++; $display("FAIL rst_ack: got %b want 0000", ack);
        end
        if (rnd_data !== 8'h00) begin
            errors++; $display("FAIL rst_rnd: got %h want 00", rnd_data);
        end
        if (busy !== 1'b1) begin
            errors++; $display("FAIL rst_busy: got %b want 1", busy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks += 1;
        if (busy !== 1'b1 || lfsr_load !== 1'b1) begin
            errors++;
            $display("FAIL init_cycle: got busy=%b load=%b want 1 1",
                     busy, lfsr_load);
        end
        tick();
        checks += 1;
        if (busy !== 1'b0 || lfsr_load !== 1'b0) begin
            errors++;
            $display("FAIL post_init: got busy=%b load=%b want 0 0",
                     busy, lfsr_load);
        end
        m_ptr = 0;
    endtask

    task automatic test_single();
        logic [3:0] a;
        logic [7:0] s, s0;
        int n;
        idle(12);
        req = 4'b0010;
        wait_ack(40, a, n, s);
        s0 = s;
        checks += 3;
        if (a !== 4'b0010) begin
            errors++; $display("FAIL single_ack: got %b want 0010", a);
        end
        if (n != 1) begin
            errors++; $display("FAIL single_lat: got %0d want 1", n);
        end
        if (rnd_data !== s) begin
            errors++; $display("FAIL single_rnd: got %h want %h", rnd_data, s);
        end
        tick();
        checks += 2;
        if (ack !== 4'b0000) begin
            errors++; $display("FAIL single_pulse: got %b want 0000", ack);
        end
        if (rnd_data !== s0) begin
            errors++; $display("FAIL single_hold: got %h want %h", rnd_data, s0);
        end
        wait_ack(40, a, n, s);
        checks += 2;
        if (a !== 4'b0010 || rnd_data !== s) begin
            errors++;
            $display("FAIL single_again: got %b/%h want 0010/%h", a, rnd_data, s);
        end
        if (n != MIN_GAP) begin
            errors++; $display("FAIL single_gap: got %0d want %0d", n, MIN_GAP);
        end
        req = 4'b0000;
        m_ptr = 2;
    endtask

    task automatic test_contention();
        logic [3:0] a, exp_a, r;
        logic [7:0] s;
        int n, exp_n;
        idle(12);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_a = pick(req, m_ptr);
            exp_n = (k == 0) ? 1 : MIN_GAP + 1;
            wait_ack(40, a, n, s);
            checks += 2;
            if (a !== exp_a || rnd_data !== s) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %b/%h want %b/%h",
                         k, a, rnd_data, exp_a, s);
            end
            if (n != exp_n) begin
                errors++;
                $display("FAIL rr_gap[%0d]: got %0d want %0d", k, n, exp_n);
            end
            m_ptr = after(exp_a);
        end
        req = 4'b0000;
        idle(12);
        req = 4'b0001;
        wait_ack(40, a, n, s);
        req = 4'b0000;
        m_ptr = after(4'b0001);
        idle(12);
        req = 4'b1001;
        wait_ack(40, a, n, s);
        checks += 1;
        if (a !== 4'b1000) begin
            errors++; $display("FAIL rr_wrap: got %b want 1000", a);
        end
        req = 4'b0000;
        m_ptr = after(4'b1000);
        for (int k = 0; k < 8; k++) begin
            idle(12);
            r = 4'($urandom_range(1, 15));
            exp_a = pick(r, m_ptr);
            req = r;
            wait_ack(40, a, n, s);
            checks += 1;
            if (a !== exp_a || n != 1 || rnd_data !== s) begin
                errors++;
                $display("FAIL rr_rand[%0d]: req=%b got %b/%0d/%h want %b/1/%h",
                         k, r, a, n, rnd_data, exp_a, s);
            end
            req = 4'b0000;
            m_ptr = after(exp_a);
        end
    endtask

    task automatic test_reseed();
        logic [3:0] a;
        logic [7:0] s;
        int n;
        idle(12);
        req = 4'b0010;
        wait_ack(40, a, n, s);
        req = 4'b0100;
        tick();
        tick();
        reseed = 1'b1;
        reseed_value = 8'h3C;
        tick();
        reseed = 1'b0;
        checks += 1;
        if (lfsr_load !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rs_defer: got load=%b busy=%b want 0 1",
                     lfsr_load, busy);
        end
        wait_ack(40, a, n, s);
        checks += 1;
        if (a !== 4'b0100 || n != MIN_GAP - 2) begin
            errors++;
            $display("FAIL rs_grant_first: got %b/%0d want 0100/%0d",
                     a, n, MIN_GAP - 2);
        end
        req = 4'b0001;
        tick();
        checks += 2;
        if (lfsr_load !== 1'b1 || lfsr_seed !== 8'h3C) begin
            errors++;
            $display("FAIL rs_load: got %b/%h want 1/3c", lfsr_load, lfsr_seed);
        end
        if (ack !== 4'b0000) begin
            errors++; $display("FAIL rs_noack: got %b want 0000", ack);
        end
        wait_ack(40, a, n, s);
        checks += 1;
        if (a !== 4'b0001 || n != MIN_GAP + 2) begin
            errors++;
            $display("FAIL rs_after_gap: got %b/%0d want 0001/%0d",
                     a, n, MIN_GAP + 2);
        end
        req = 4'b0000;
        m_ptr = 1;
        idle(12);
        reseed = 1'b1;
        reseed_value = 8'hFF;
        tick();
        reseed = 1'b0;
        checks += 1;
        if (lfsr_load !== 1'b0) begin
            errors++; $display("FAIL rsff_early: got %b want 0", lfsr_load);
        end
        tick();
        checks += 1;
        if (lfsr_load !== 1'b1 || lfsr_seed !== 8'h5A) begin
            errors++;
            $display("FAIL rsff_seed: got %b/%h want 1/5a", lfsr_load, lfsr_seed);
        end
        tick();
        checks += 1;
        if (lfsr_load !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rsff_done: got %b/%b want 0/0", lfsr_load, busy);
        end
    endtask

    task automatic test_lockup();
        logic [3:0] a;
        logic [7:0] s;
        int n;
        reseed = 1'b1;
        reseed_value = 8'hA7;
        tick();
        reseed = 1'b0;
        idle(14);
        req = 4'b0001;
        rand_lfsr = 1'b0;
        lfsr_state = 8'hFF;
        tick();
        rand_lfsr = 1'b1;
        lfsr_state = rnd8();
        checks += 2;
        if (ack !== 4'b0000) begin
            errors++; $display("FAIL lock_noack: got %b want 0000", ack);
        end
        if (lfsr_load !== 1'b1 || lfsr_seed !== 8'h5A) begin
            errors++;
            $display("FAIL lock_seed: got %b/%h want 1/5a", lfsr_load, lfsr_seed);
        end
        wait_ack(40, a, n, s);
        checks += 1;
        if (a !== 4'b0001 || n != MIN_GAP + 2 || rnd_data !== s) begin
            errors++;
            $display("FAIL lock_grant: got %b/%0d/%h want 0001/%0d/%h",
                     a, n, rnd_data, MIN_GAP + 2, s);
        end
        req = 4'b0000;
        m_ptr = 1;
    endtask

    task automatic test_abort_reset();
        logic [3:0] a, exp_a;
        logic [7:0] s;
        int n, seen;
        idle(12);
        req = 4'b0001;
        wait_ack(40, a, n, s);
        m_ptr = 1;
        req = 4'b0100;
        tick();
        tick();
        tick();
        req = 4'b0000;
        tick();
        checks += 1;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL abort_idle: got busy=%b want 0", busy);
        end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (ack !== 4'b0000) seen++;
        end
        checks += 1;
        if (seen != 0) begin
            errors++; $display("FAIL abort_noack: got %0d acks want 0", seen);
        end
        req = 4'b1111;
        exp_a = pick(4'b1111, m_ptr);
        wait_ack(40, a, n, s);
        checks += 1;
        if (a !== exp_a || n != 1) begin
            errors++;
            $display("FAIL abort_ptr: got %b/%0d want %b/1", a, n, exp_a);
        end
        req = 4'b0000;
        idle(12);
        req = 4'b0010;
        wait_ack(40, a, n, s);
        req = 4'b1000;
        tick();
        tick();
        reseed = 1'b1;
        reseed_value = 8'h3C;
        tick();
        reseed = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (ack !== 4'b0000 || rnd_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_out: got %b/%h want 0000/00", ack, rnd_data);
        end
        if (lfsr_load !== 1'b1 || busy !== 1'b1 || lfsr_seed !== 8'h5A) begin
            errors++;
            $display("FAIL rst_mid_load: got %b/%b/%h want 1/1/5a",
                     lfsr_load, busy, lfsr_seed);
        end
        #2;
        rst_n = 1'b1;
        req = 4'b0000;
        tick();
        m_ptr = 0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (lfsr_load !== 1'b0) seen++;
        end
        checks += 1;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_drop_reseed: got %0d loads want 0", seen);
        end
        req = 4'b1111;
        exp_a = pick(4'b1111, m_ptr);
        wait_ack(40, a, n, s);
        checks += 1;
        if (a !== exp_a || n != 1) begin
            errors++;
            $display("FAIL rst_ptr: got %b/%0d want %b/1", a, n, exp_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 1;
        if (ack !== 4'b0000) begin
            errors++; $display("FAIL rst_ack_kill: got %b want 0000", ack);
        end
        req = 4'b0000;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        m_ptr        = 0;
        rand_lfsr    = 1'b1;
        req          = 4'b0000;
        reseed       = 1'b0;
        reseed_value = 8'h00;
        lfsr_state   = rnd8();
        pre          = 8'h00;
        rst_n        = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_reseed();
        test_lockup();
        test_abort_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
